fetch_sequencer: RTL

//  Instruction fetch/sequencing front end of the accumulator CPU; produces the op_i stream the control unit decodes.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_sequencer_branch_resolve.sv | 17 +
 rtl/fetch_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU front end: opcode encodings and fetch FSM states.
package cpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STA = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_JC  = 3'b110;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_branch_resolve.sv
// Combinational jump decision: a jump is taken only when the control unit strobes jmp
// and the opcode is a jump whose condition flag (if any) is set.
module branch_resolve
  import cpu_pkg::*;
(
  input  logic [2:0] op,
  input  logic       jmp,
  input  logic       z,
  input  logic       c,
  output logic       taken
);

  assign taken = jmp & ((op == OP_JMP) |
                        ((op == OP_JZ) & z) |
                        ((op == OP_JC) & c));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing front end: owns PC and IR, fetches over req/ack,
// pulses ivalid_o once per instruction and resolves jumps when execution completes.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int IW       = 8,
  parameter int AW       = 5,
  parameter int RESET_PC = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic [IW-1:0] imem_data_i,
  output logic [2:0]    op_o,
  output logic [AW-1:0] operand_o,
  output logic          ivalid_o,
  input  logic          jmp_i,
  input  logic          z_i,
  input  logic          c_i,
  input  logic          exec_done_i,
  input  logic          halt_i,
  output logic [AW-1:0] pc_o,
  output logic          halted_o
);

  localparam logic [AW-1:0] PC_INIT = AW'(RESET_PC);

  fetch_state_t  state;
  logic [IW-1:0] ir;
  logic [AW-1:0] pc;
  logic          req;
  logic          ivalid;
  logic          halted;
  logic          taken;

  assign op_o        = ir[IW-1 -: 3];
  assign operand_o   = ir[AW-1:0];
  assign imem_req_o  = req;
  assign imem_addr_o = pc;
  assign pc_o        = pc;
  assign ivalid_o    = ivalid;
  assign halted_o    = halted;

  branch_resolve u_branch_resolve (
    .op    (op_o),
    .jmp   (jmp_i),
    .z     (z_i),
    .c     (c_i),
    .taken (taken)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= FETCH;
      pc     <= PC_INIT;
      ir     <= '0;
      req    <= 1'b0;
      ivalid <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // Acks only count against a request we are actually presenting,
          // so an ack arriving in the first cycle after reset is dropped.
          if (!req) begin
            req <= 1'b1;
          end else if (imem_ack_i) begin
            ir     <= imem_data_i;
            req    <= 1'b0;
            ivalid <= 1'b1;
            state  <= DECODE;
          end
        end
        DECODE: begin
          ivalid <= 1'b0;
          state  <= EXEC;
        end
        EXEC: begin
          if (exec_done_i) begin
            if (halt_i) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc    <= taken ? operand_o : pc + AW'(1);
              req   <= 1'b1;
              state <= FETCH;
            end
          end
        end
        default: begin
          req    <= 1'b0;
          ivalid <= 1'b0;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule
